// File: rtl/sobel_host_ctrl.sv
// sobel_host_ctrl: streams a frame into sobel_top, runs it under a watchdog, streams the result back out
module sobel_host_ctrl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int N_PIX       = 65536,
    parameter int TIMEOUT_CYC = 2**20
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    input  logic                  out_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic                  start_o,
    input  logic                  finish_i,
    output logic                  wr_en_imem_o,
    output logic [ADDR_WIDTH-1:0] addr_imem_o,
    output logic [DATA_WIDTH-1:0] data_imem_o,
    output logic                  rd_en_omem_o,
    output logic [ADDR_WIDTH-1:0] addr_omem_o,
    input  logic [DATA_WIDTH-1:0] data_omem_i
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N_PIX - 1);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, UNLOAD} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ld_cnt_q, ld_cnt_d, rd_addr_q, rd_addr_d, out_cnt_q, out_cnt_d;
    logic [TW-1:0]         wd_q, wd_d;
    logic                  rd_done_q, rd_done_d, inflight_q, timeout_q, timeout_d;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            fcnt_q;
    logic                  pop, issue;

    assign in_ready_o   = (state_q == LOAD) & ~rst_i;
    assign wr_en_imem_o = in_valid_i & in_ready_o;
    assign addr_imem_o  = in_ready_o ? ld_cnt_q : '0;
    assign data_imem_o  = rst_i ? '0 : in_data_i;
    assign start_o      = (state_q == START) & ~rst_i;
    assign busy_o       = (state_q == START || state_q == RUN || state_q == UNLOAD) & ~rst_i;
    assign timeout_o    = timeout_q & ~rst_i;
    assign rd_en_omem_o = (state_q == UNLOAD) & ~rst_i;
    assign addr_omem_o  = rd_en_omem_o ? rd_addr_q : '0;
    assign out_valid_o  = rd_en_omem_o & (fcnt_q != 2'd0);
    assign out_data_o   = out_valid_o ? fifo_q[rd_ptr_q] : '0;
    assign out_last_o   = out_valid_o & (out_cnt_q == LAST);
    assign pop          = out_valid_o & out_ready_i;
    assign done_o       = pop & (out_cnt_q == LAST);
    // A slot freed by this cycle's pop counts as room, so reads keep pace at one pixel per cycle
    assign issue        = rd_en_omem_o & ~rd_done_q & ((3'(fcnt_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));

    // Next-state logic for the frame sequencer and its counters
    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        rd_addr_d = rd_addr_q;
        out_cnt_d = out_cnt_q;
        rd_done_d = rd_done_q;
        timeout_d = timeout_q;
        wd_d      = '0;
        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: if (wr_en_imem_o) begin
                ld_cnt_d = (ld_cnt_q == LAST) ? '0 : ld_cnt_q + 1'b1;
                state_d  = (ld_cnt_q == LAST) ? START : LOAD;
            end
            START: begin
                timeout_d = 1'b0;
                state_d   = RUN;
            end
            RUN: if (finish_i) state_d = UNLOAD;
                 else if (wd_q == WD_LAST) begin
                     timeout_d = 1'b1;
                     state_d   = LOAD;
                 end else wd_d = wd_q + 1'b1;
            UNLOAD: begin
                if (issue) begin
                    rd_done_d = rd_addr_q == LAST;
                    rd_addr_d = (rd_addr_q == LAST) ? rd_addr_q : rd_addr_q + 1'b1;
                end
                if (pop) out_cnt_d = out_cnt_q + 1'b1;
                if (done_o) begin
                    state_d   = LOAD;
                    rd_addr_d = '0;
                    out_cnt_d = '0;
                    rd_done_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ld_cnt_q   <= '0;
            rd_addr_q  <= '0;
            out_cnt_q  <= '0;
            wd_q       <= '0;
            rd_done_q  <= 1'b0;
            inflight_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            rd_addr_q  <= rd_addr_d;
            out_cnt_q  <= out_cnt_d;
            wd_q       <= wd_d;
            rd_done_q  <= rd_done_d;
            inflight_q <= issue;
            timeout_q  <= timeout_d;
        end
    end

    // Two-entry result FIFO fed by read data arriving one cycle after each issued read
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fcnt_q   <= 2'd0;
        end else begin
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= data_omem_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            fcnt_q <= fcnt_q + 2'(inflight_q) - 2'(pop);
        end
    end
endmodule
